alu32_sched: RTL

- Two-requester scheduler that shares one combinational 32-bit ALU and flag unit (op encoding 3 bits, flags n/z/c/v).
- Arbitrates round-robin, registers the operands into the ALU, captures result plus flags, and returns them through a per-requester valid/ready response.
- Sits between the two instruction-issue ports and the shared ALU32 datapath.

---
 rtl/alu32_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/alu32_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu32_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu32_pkg : op codes, scheduler states and flag bit positions
// Rev 1.0
// ------------------------------------------------------------------
package alu32_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arb2 : two-way round-robin grant; a tie goes to ~last_grant
// Rev 1.0
// ------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       grant_valid
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
    grant_valid  = |req;
    last_grant_d = update ? grant : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/alu32_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// alu32_sched : shares one 32-bit ALU between two requesters
// Optional op counters / overflow flag under ALU_SCHED_STATS_EN. Rev 1.0
// ------------------------------------------------------------------
module alu32_sched
  import alu32_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]       op_cnt0,
  output logic [15:0]       op_cnt1,
  output logic              ovf_seen
`endif
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              busy_q, busy_d;

  logic grant;
  logic grant_valid;
  logic accept;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req_valid),
    .update      (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    req_ready    = 2'b00;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          owner_d          = grant;
          alu_op_d         = grant ? req_op1 : req_op0;
          alu_a_d          = grant ? req_a1  : req_a0;
          alu_b_d          = grant ? req_b1  : req_b0;
          state_d          = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d         = alu_result;
        rsp_flags_d[FLAG_N]  = alu_n;
        rsp_flags_d[FLAG_Z]  = alu_z;
        rsp_flags_d[FLAG_C]  = alu_c;
        rsp_flags_d[FLAG_V]  = alu_v;
        rsp_valid_d          = 2'b00;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = S_RESP;
      end
      S_RESP: begin
        // Only the owner's ready completes the response
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = busy_q;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] op_cnt0_q, op_cnt0_d;
  logic [15:0] op_cnt1_q, op_cnt1_d;
  logic        ovf_seen_q, ovf_seen_d;
  logic        rsp_hs;

  assign rsp_hs = (state_q == S_RESP) && rsp_ready[owner_q];

  always_comb begin
    op_cnt0_d  = op_cnt0_q;
    op_cnt1_d  = op_cnt1_q;
    ovf_seen_d = ovf_seen_q;
    if (rsp_hs && !owner_q && (op_cnt0_q != 16'hFFFF)) op_cnt0_d = op_cnt0_q + 16'd1;
    if (rsp_hs &&  owner_q && (op_cnt1_q != 16'hFFFF)) op_cnt1_d = op_cnt1_q + 16'd1;
    if ((state_q == S_EXEC) && ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) && alu_v)
      ovf_seen_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_cnt0_q  <= 16'd0;
      op_cnt1_q  <= 16'd0;
      ovf_seen_q <= 1'b0;
    end else begin
      op_cnt0_q  <= op_cnt0_d;
      op_cnt1_q  <= op_cnt1_d;
      ovf_seen_q <= ovf_seen_d;
    end
  end

  assign op_cnt0  = op_cnt0_q;
  assign op_cnt1  = op_cnt1_q;
  assign ovf_seen = ovf_seen_q;
`endif

endmodule
`default_nettype wire
